// File: rtl/ga23_cpu_bridge_if.sv
// Host request and GA23 VRAM port signals of the CPU bridge. The master modport is the side
// driving requests and modelling GA23; the slave modport is the bridge itself.
interface ga23_cpu_bridge_if;
    logic [15:0] host_addr;
    logic [15:0] host_din;
    logic [1:0]  host_be;
    logic        host_rd;
    logic        host_wr;
    logic [15:0] host_dout;
    logic        host_ack;
    logic        host_err;
    logic        ga_mem_cs;
    logic        ga_mem_rd;
    logic        ga_mem_wr;
    logic [15:0] ga_addr;
    logic [15:0] ga_din;
    logic        ga_busy;
    logic [15:0] ga_dout;

    modport master (
        output host_addr, host_din, host_be, host_rd, host_wr, ga_busy, ga_dout,
        input  host_dout, host_ack, host_err, ga_mem_cs, ga_mem_rd, ga_mem_wr, ga_addr, ga_din
    );

    modport slave (
        input  host_addr, host_din, host_be, host_rd, host_wr, ga_busy, ga_dout,
        output host_dout, host_ack, host_err, ga_mem_cs, ga_mem_rd, ga_mem_wr, ga_addr, ga_din
    );
endinterface

// File: rtl/ga23_cpu_bridge.sv
// Host-side initiator for the GA23 CPU VRAM port: level requests to strobe/busy handshake.
// Define GA23_BRIDGE_RMW_EN to turn partial-byte writes into read-merge-write sequences.
module ga23_cpu_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input logic              clk,
    input logic              reset_n,
    ga23_cpu_bridge_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StGap,
        StStrobe,
        StWaitHi,
        StWaitLo,
        StDone
`ifdef GA23_BRIDGE_RMW_EN
        , StMerge
`endif
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            phase_wr_q, phase_wr_d;
    logic            err_q, err_d;
    logic [15:0]     addr_q, addr_d;
    logic [15:0]     din_q, din_d;
    logic [15:0]     dout_q, dout_d;
`ifdef GA23_BRIDGE_RMW_EN
    logic            rmw_q, rmw_d;
    logic [1:0]      be_q, be_d;
`endif
    logic            strobe;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            phase_wr_q <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            dout_q     <= '0;
`ifdef GA23_BRIDGE_RMW_EN
            rmw_q      <= 1'b0;
            be_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            phase_wr_q <= phase_wr_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
`ifdef GA23_BRIDGE_RMW_EN
            rmw_q      <= rmw_d;
            be_q       <= be_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        phase_wr_d = phase_wr_q;
        err_d      = err_q;
        addr_d     = addr_q;
        din_d      = din_q;
        dout_d     = dout_q;
`ifdef GA23_BRIDGE_RMW_EN
        rmw_d      = rmw_q;
        be_d       = be_q;
`endif
        unique case (state_q)
            StIdle: begin
                err_d = 1'b0;
                if (bus.host_wr) begin
                    if (bus.host_be == 2'b00) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = bus.host_addr;
                        din_d   = bus.host_din;
                        state_d = StGap;
`ifdef GA23_BRIDGE_RMW_EN
                        be_d       = bus.host_be;
                        rmw_d      = (bus.host_be != 2'b11);
                        phase_wr_d = (bus.host_be == 2'b11);
`else
                        phase_wr_d = 1'b1;
`endif
                    end
                end else if (bus.host_rd) begin
                    addr_d     = bus.host_addr;
                    phase_wr_d = 1'b0;
                    state_d    = StGap;
`ifdef GA23_BRIDGE_RMW_EN
                    rmw_d      = 1'b0;
`endif
                end
            end
            // Guarantees a strobe-low cycle so GA23 sees a fresh rising edge.
            StGap: begin
                cnt_d   = '0;
                state_d = StStrobe;
            end
            StStrobe: begin
                state_d = StWaitHi;
            end
            StWaitHi: begin
                if (bus.ga_busy) begin
                    state_d = StWaitLo;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    dout_d  = 16'hFFFF;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaitLo: begin
                if (!bus.ga_busy) begin
                    dout_d  = bus.ga_dout;
                    state_d = StDone;
`ifdef GA23_BRIDGE_RMW_EN
                    if (rmw_q && !phase_wr_q) begin
                        state_d = StMerge;
                    end
`endif
                end
            end
`ifdef GA23_BRIDGE_RMW_EN
            StMerge: begin
                din_d[15:8] = be_q[1] ? din_q[15:8] : dout_q[15:8];
                din_d[7:0]  = be_q[0] ? din_q[7:0]  : dout_q[7:0];
                phase_wr_d  = 1'b1;
                state_d     = StGap;
            end
`endif
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Strobes decode straight from state so reset drops them without waiting for a clock.
    assign strobe        = (state_q == StStrobe) || (state_q == StWaitHi);
    assign bus.ga_mem_cs = strobe;
    assign bus.ga_mem_rd = strobe & ~phase_wr_q;
    assign bus.ga_mem_wr = strobe & phase_wr_q;
    assign bus.ga_addr   = addr_q & 16'hFFFE;
    assign bus.ga_din    = din_q;
    assign bus.host_dout = dout_q;
    assign bus.host_ack  = (state_q == StDone);
    assign bus.host_err  = (state_q == StDone) & err_q;
endmodule

// File: tb/tb_ga23_cpu_bridge.sv
// Directed bench for ga23_cpu_bridge with a small GA23 VRAM-port model.
`timescale 1ns/1ps
module tb_ga23_cpu_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   passes = 0;

    ga23_cpu_bridge_if bus ();

    ga23_cpu_bridge #(.TIMEOUT(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // GA23 model: accepts a rising strobe while idle, stays busy for svc cycles.
    logic [15:0] mem [0:511];
    logic        model_rst = 1'b1;
    logic        ga_dead = 1'b0;
    int          svc = 2;
    int          busy_cnt = 0;
    logic        cs_prev = 1'b0;
    int          cs_rises = 0;
    int          cs_hi = 0;
    int          ack_cnt = 0;
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = 16'h0;
    logic [15:0] poke_data = 16'h0;

    always @(posedge clk) begin
        if (model_rst) begin
            bus.ga_busy <= 1'b0;
            bus.ga_dout <= 16'h0;
            busy_cnt    <= 0;
            cs_prev     <= 1'b0;
        end else begin
            cs_prev <= bus.ga_mem_cs;
            if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) bus.ga_busy <= 1'b0;
            end else if (bus.ga_mem_cs && !cs_prev && !ga_dead) begin
                bus.ga_busy <= 1'b1;
                busy_cnt    <= svc;
                if (bus.ga_mem_wr) mem[bus.ga_addr[9:1]] <= bus.ga_din;
                else               bus.ga_dout <= mem[bus.ga_addr[9:1]];
            end
            if (bus.ga_mem_cs && !cs_prev) cs_rises <= cs_rises + 1;
            if (bus.ga_mem_cs)             cs_hi    <= cs_hi + 1;
            if (bus.host_ack)              ack_cnt  <= ack_cnt + 1;
        end
        if (poke_en) mem[poke_addr[9:1]] <= poke_data;
    end

    task automatic poke(input logic [15:0] addr, input logic [15:0] data);
        poke_addr = addr;
        poke_data = data;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    // Presents a request and waits (bounded) for host_ack; optionally leaves it asserted.
    task automatic access(input logic wr, input logic rd, input logic [15:0] addr,
                          input logic [15:0] din, input logic [1:0] be, input bit hold,
                          output logic got, output logic [15:0] dout, output logic err,
                          output int lat);
        bus.host_wr   = wr;
        bus.host_rd   = rd;
        bus.host_addr = addr;
        bus.host_din  = din;
        bus.host_be   = be;
        got  = 1'b0;
        dout = 16'hxxxx;
        err  = 1'bx;
        lat  = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.host_ack) begin
                got  = 1'b1;
                dout = bus.host_dout;
                err  = bus.host_err;
            end
        end
        if (!hold) begin
            bus.host_wr = 1'b0;
            bus.host_rd = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [15:0] exp_zero;
        exp_zero = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ga_mem_cs, bus.ga_mem_rd, bus.ga_mem_wr} !== 3'b000)
            $display("FAIL reset_strobes: got %b want 000",
                     {bus.ga_mem_cs, bus.ga_mem_rd, bus.ga_mem_wr});
        else passes++;
        checks++;
        if ({bus.host_ack, bus.host_err} !== 2'b00)
            $display("FAIL reset_ack_err: got %b want 00", {bus.host_ack, bus.host_err});
        else passes++;
        checks++;
        if (bus.host_dout !== exp_zero)
            $display("FAIL reset_host_dout: got %h want %h", bus.host_dout, exp_zero);
        else passes++;
        checks++;
        if (bus.ga_addr !== exp_zero)
            $display("FAIL reset_ga_addr: got %h want %h", bus.ga_addr, exp_zero);
        else passes++;
        checks++;
        if (bus.ga_din !== exp_zero)
            $display("FAIL reset_ga_din: got %h want %h", bus.ga_din, exp_zero);
        else passes++;
        reset_n   = 1'b1;
        model_rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        logic got, err;
        logic [15:0] dout;
        int lat, rises0;
        poke(16'h0200, 16'h1234);
        repeat (3) @(negedge clk);
        rises0 = cs_rises;
        access(1'b0, 1'b1, 16'h0200, 16'h0000, 2'b11, 1'b0, got, dout, err, lat);
        checks++;
        if (got !== 1'b1) $display("FAIL read_ack: got %b want 1", got); else passes++;
        checks++;
        if (dout !== 16'h1234) $display("FAIL read_dout: got %h want 1234", dout); else passes++;
        checks++;
        if (err !== 1'b0) $display("FAIL read_err: got %b want 0", err); else passes++;
        checks++;
        if (lat != 6) $display("FAIL read_latency: got %0d want 6", lat); else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (cs_rises - rises0 != 1)
            $display("FAIL read_cs_edges: got %0d want 1", cs_rises - rises0);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic got1, got2, err1, err2;
        logic [15:0] dout;
        logic [15:0] mid;
        int lat, rises0;
        repeat (3) @(negedge clk);
        rises0 = cs_rises;
        access(1'b1, 1'b0, 16'h0010, 16'hAAAA, 2'b11, 1'b1, got1, dout, err1, lat);
        mid = mem[9'h008];
        access(1'b1, 1'b0, 16'h0010, 16'h5555, 2'b11, 1'b0, got2, dout, err2, lat);
        repeat (3) @(negedge clk);
        checks++;
        if ({got1, got2, err1, err2} !== 4'b1100)
            $display("FAIL b2b_ack_err: got %b want 1100", {got1, got2, err1, err2});
        else passes++;
        checks++;
        if (mid !== 16'hAAAA) $display("FAIL b2b_first_word: got %h want aaaa", mid);
        else passes++;
        checks++;
        if (mem[9'h008] !== 16'h5555)
            $display("FAIL b2b_final_word: got %h want 5555", mem[9'h008]);
        else passes++;
        checks++;
        if (cs_rises - rises0 != 2)
            $display("FAIL b2b_cs_edges: got %0d want 2", cs_rises - rises0);
        else passes++;
    endtask

    task automatic test_byte_write();
        logic got, err;
        logic [15:0] dout, exp_word;
        int lat, rises0, acks0, exp_rises;
`ifdef GA23_BRIDGE_RMW_EN
        exp_word  = 16'hAB34;
        exp_rises = 2;
`else
        exp_word  = 16'hAB00;
        exp_rises = 1;
`endif
        poke(16'h0200, 16'h1234);
        repeat (3) @(negedge clk);
        rises0 = cs_rises;
        acks0  = ack_cnt;
        access(1'b1, 1'b0, 16'h0200, 16'hAB00, 2'b10, 1'b0, got, dout, err, lat);
        repeat (5) @(negedge clk);
        checks++;
        if ({got, err} !== 2'b10) $display("FAIL byte_ack_err: got %b want 10", {got, err});
        else passes++;
        checks++;
        if (mem[9'h100] !== exp_word)
            $display("FAIL byte_word: got %h want %h", mem[9'h100], exp_word);
        else passes++;
        checks++;
        if (cs_rises - rises0 != exp_rises)
            $display("FAIL byte_cs_edges: got %0d want %0d", cs_rises - rises0, exp_rises);
        else passes++;
        checks++;
        if (ack_cnt - acks0 != 1)
            $display("FAIL byte_ack_count: got %0d want 1", ack_cnt - acks0);
        else passes++;
    endtask

    task automatic test_timeout();
        logic got, err;
        logic [15:0] dout;
        int lat, hi0;
        ga_dead = 1'b1;
        repeat (3) @(negedge clk);
        hi0 = cs_hi;
        access(1'b0, 1'b1, 16'h0200, 16'h0000, 2'b11, 1'b0, got, dout, err, lat);
        checks++;
        if ({got, err} !== 2'b11) $display("FAIL timeout_ack_err: got %b want 11", {got, err});
        else passes++;
        checks++;
        if (dout !== 16'hFFFF) $display("FAIL timeout_dout: got %h want ffff", dout);
        else passes++;
        checks++;
        if (bus.ga_mem_cs !== 1'b0) $display("FAIL timeout_cs_at_ack: got %b want 0", bus.ga_mem_cs);
        else passes++;
        // One STROBE cycle plus 64 WAIT_HI cycles.
        checks++;
        if (cs_hi - hi0 != 65) $display("FAIL timeout_strobe_cycles: got %0d want 65", cs_hi - hi0);
        else passes++;
        checks++;
        if (lat != 67) $display("FAIL timeout_latency: got %0d want 67", lat); else passes++;
        ga_dead = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        logic got, err, seen;
        logic [15:0] dout;
        int lat;
        svc = 6;
        repeat (3) @(negedge clk);
        bus.host_rd   = 1'b1;
        bus.host_wr   = 1'b0;
        bus.host_addr = 16'h0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.ga_busy === 1'b1 && bus.ga_mem_cs === 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b1) $display("FAIL rst_mid_reach_wait_lo: got %b want 1", seen);
        else passes++;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.ga_mem_cs, bus.ga_mem_rd, bus.ga_mem_wr, bus.host_ack} !== 4'b0000)
            $display("FAIL rst_mid_outputs: got %b want 0000",
                     {bus.ga_mem_cs, bus.ga_mem_rd, bus.ga_mem_wr, bus.host_ack});
        else passes++;
        bus.host_rd = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b1;
        svc = 2;
        repeat (3) @(negedge clk);
        access(1'b0, 1'b1, 16'h0010, 16'h0000, 2'b11, 1'b0, got, dout, err, lat);
        checks++;
        if ({got, err} !== 2'b10) $display("FAIL rst_mid_reread_ack: got %b want 10", {got, err});
        else passes++;
        checks++;
        if (dout !== 16'h5555) $display("FAIL rst_mid_reread_dout: got %h want 5555", dout);
        else passes++;
    endtask

    task automatic test_degenerate();
        logic got, err;
        logic [15:0] dout;
        int lat, rises0;
        repeat (3) @(negedge clk);
        rises0 = cs_rises;
        access(1'b1, 1'b0, 16'h0010, 16'hDEAD, 2'b00, 1'b0, got, dout, err, lat);
        repeat (3) @(negedge clk);
        checks++;
        if (got !== 1'b1 || lat > 2)
            $display("FAIL be0_ack: got ack=%b lat=%0d want ack=1 lat<=2", got, lat);
        else passes++;
        checks++;
        if (cs_rises != rises0) $display("FAIL be0_no_strobe: got %0d want 0", cs_rises - rises0);
        else passes++;
        checks++;
        if (mem[9'h008] !== 16'h5555) $display("FAIL be0_word: got %h want 5555", mem[9'h008]);
        else passes++;
        access(1'b1, 1'b1, 16'h0010, 16'h0F0F, 2'b11, 1'b0, got, dout, err, lat);
        repeat (3) @(negedge clk);
        checks++;
        if ({got, err} !== 2'b10) $display("FAIL rdwr_ack: got %b want 10", {got, err});
        else passes++;
        checks++;
        if (mem[9'h008] !== 16'h0F0F) $display("FAIL rdwr_write_wins: got %h want 0f0f", mem[9'h008]);
        else passes++;
    endtask

    initial begin
        bus.host_addr = 16'h0;
        bus.host_din  = 16'h0;
        bus.host_be   = 2'b00;
        bus.host_rd   = 1'b0;
        bus.host_wr   = 1'b0;
        test_reset();
        test_read();
        test_back_to_back();
        test_byte_write();
        test_timeout();
        test_reset_mid_access();
        test_degenerate();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ga23_cpu_bridge.md
# ga23_cpu_bridge

Host-side initiator for the GA23 tilemap chip's CPU VRAM port. It converts held-level CPU read and write requests, with byte enables, into the GA23 strobe/busy handshake and returns a single-cycle acknowledge with read data. It sits between the main CPU bus decoder and the GA23 `mem_cs`/`mem_rd`/`mem_wr`/`busy`/`cpu_dout` pins. IO register writes (`io_wr`) do not pass through this block.

## Interface
- `TIMEOUT`, default 64: cycles to wait for `ga_busy` to rise after strobe assertion before the access is aborted.
- `clk  in  1`: system clock, the same clock that runs GA23.
- `reset_n  in  1`: asynchronous, active-low reset.
- `host_addr  in  16`: byte address within the VRAM window. Bit 0 is ignored.
- `host_din  in  16`: write data.
- `host_be  in  2`: byte enables; [1] is the high byte, [0] the low byte.
- `host_rd`, `host_wr  in  1`: request levels, held until `host_ack`.
- `host_dout  out  16`: read data, valid in the `host_ack` cycle.
- `host_ack  out  1`: one-cycle completion pulse.
- `host_err  out  1`: one-cycle pulse coincident with `host_ack` when the access timed out.
- `ga_mem_cs`, `ga_mem_rd`, `ga_mem_wr  out  1`: GA23 access strobes.
- `ga_addr  out  16`: address to GA23.
- `ga_din  out  16`: write data to GA23.
- `ga_busy  in  1`: GA23 busy.
- `ga_dout  in  16`: GA23 read data.

## Operation
- Reset values: all strobes 0, `host_ack` 0, `host_err` 0, `host_dout` 0, `ga_addr` 0, `ga_din` 0. State resets to IDLE.
- States: IDLE, GAP, STROBE, WAIT_HI, WAIT_LO, MERGE (RMW builds only), DONE.
- **IDLE**
  - `host_wr` takes priority over `host_rd` if both are asserted.
  - A write with `host_be==0` goes to DONE with no GA23 access.
  - Otherwise latch address, data and byte enables, then go to GA23 access.
- **GA23 access**
  - In STROBE, drive `ga_mem_cs=1` and `ga_mem_rd` or `ga_mem_wr`.
  - Stay in WAIT_HI with strobes held until `ga_busy==1`. Then drop all strobes and go to WAIT_LO.
  - In WAIT_LO, on `ga_busy==0`, capture `ga_dout` into the data register.
- **Strobe gap**: GA23 accepts only a rising strobe edge while not busy. Strobes are therefore always low for at least one cycle (GAP) between any two GA23 accesses, including the two phases of an RMW.
- **Timeout**
  - The counter counts only in WAIT_HI.
  - After `TIMEOUT` cycles: drop strobes, set `host_dout=16'hFFFF`, and go to DONE with `host_err`.
  - WAIT_LO has no timeout.
- **DONE**: pulse `host_ack` for one cycle, then return to IDLE. A request still held in that cycle is not restarted until the next IDLE cycle.
- **Early request removal**: a request removed before ack still completes and acks.
- **Reset mid-access**: strobes drop asynchronously. Any GA23 access already captured completes inside GA23 unobserved.

## Timing
- Cycle-level read (n = request cycle):
  - n: IDLE sees `host_rd`.
  - n+1: GAP.
  - n+2: strobes high.
  - Strobes stay high until the first cycle that samples `ga_busy=1`; they are low from the next cycle.
- Ack timing:
  - `host_ack` asserts the cycle after `ga_busy` is sampled low.
  - `host_dout` equals `ga_dout` as sampled in that busy-low cycle.
- Minimum read latency: 5 cycles plus GA23 service time, which is bounded by its 8-slot pixel schedule.
- Write latency equals read latency.
- A full-word write, or any write without the RMW feature: `ga_din=host_din`.

## Configuration
- `GA23_BRIDGE_RMW_EN` defined:
  - Writes with `host_be` equal to 01 or 10 perform a read access, then MERGE (one cycle), then GAP, then a write access.
  - Merged word: `{be[1]?din[15:8]:rd[15:8], be[0]?din[7:0]:rd[7:0]}`.
  - A single `host_ack` is issued after the write completes.
  - A timeout in either phase aborts with `host_err`. The write phase is not issued if the read phase timed out.
- `GA23_BRIDGE_RMW_EN` undefined: partial writes are issued as one full-word write of `host_din`. The unselected lane is overwritten.

## Test plan
- **Read**: GA23 model holds word 0x1234 at 0x0200. `host_rd`, addr 0x0200 -> one `host_ack`, `host_dout=0x1234`, `host_err=0`, exactly one `ga_mem_cs` rising edge.
- **Back-to-back writes**: writes 0xAAAA then 0x5555 to 0x0010, request held continuously -> two GA23 accesses, each separated by at least one strobe-low cycle. Final word is 0x5555.
- **Byte write (RMW on)**: word is 0x1234, write `be=10` `din=0xAB00` -> read then write, stored word 0xAB34, one ack. With RMW off, the stored word is 0xAB00.
- **Timeout**: GA23 model never raises busy, `TIMEOUT=64` -> strobes drop after 64 WAIT_HI cycles, `host_ack` with `host_err` and `host_dout=0xFFFF`.
- **Reset mid-access**: assert `reset_n=0` during WAIT_LO -> strobes and ack are 0 immediately. After release, a new read completes normally.
- **Degenerate requests**: `host_be=0` write -> ack within 2 cycles, no strobe. `host_rd` and `host_wr` both asserted -> a write is performed.
